// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - register map, bit positions, mode codes and entry type for the CORDIC operand queue
package cordic_pkg;

  localparam int CORDIC_MAX_W = 32;

  localparam int ADDR_XSTAGE = 0;
  localparam int ADDR_YSTAGE = 1;
  localparam int ADDR_ZSTAGE = 2;
  localparam int ADDR_CTRL   = 3;
  localparam int ADDR_STATUS = 4;

  localparam int CTRL_PUSH_BIT  = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int CTRL_FLUSH_BIT = 2;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // Operands are held sign-extended to the full bus width so readback needs no extra logic.
  typedef struct packed {
    logic [CORDIC_MAX_W-1:0] x;
    logic [CORDIC_MAX_W-1:0] y;
    logic [CORDIC_MAX_W-1:0] z;
    logic                    mode;
  } cordic_entry_t;

endpackage

// File: rtl/cordic_op_fifo.sv
// rtl/cordic_op_fifo.sv - synchronous show-ahead FIFO with push, pop and flush
module cordic_op_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so a full queue still accepts a concurrent push.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cordic_operand_queue.sv
// rtl/cordic_operand_queue.sv - bus-programmable staging registers and operand queue feeding the CORDIC core
module cordic_operand_queue
  import cordic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic [31:0]       bus_data_in,
  input  logic              bus_rd,
  output logic [31:0]       bus_data_out,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_x,
  output logic [DATA_W-1:0] op_y,
  output logic [DATA_W-1:0] op_z,
  output logic              op_mode
);

  localparam int ENTRY_W = 3 * DATA_W + 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  cordic_entry_t     stage_q, stage_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       status_word;
  logic [DATA_W-1:0] wr_operand;
  logic              sel_x, sel_y, sel_z, sel_ctrl, sel_status;
  logic              ctrl_wr, push_req, flush_req, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  assign sel_x      = (bus_addr == ADDR_W'(ADDR_XSTAGE));
  assign sel_y      = (bus_addr == ADDR_W'(ADDR_YSTAGE));
  assign sel_z      = (bus_addr == ADDR_W'(ADDR_ZSTAGE));
  assign sel_ctrl   = (bus_addr == ADDR_W'(ADDR_CTRL));
  assign sel_status = (bus_addr == ADDR_W'(ADDR_STATUS));

  assign wr_operand = bus_data_in[DATA_W-1:0];
  assign ctrl_wr    = bus_wr && sel_ctrl;
  assign flush_req  = ctrl_wr && bus_data_in[CTRL_FLUSH_BIT];
  assign push_req   = ctrl_wr && bus_data_in[CTRL_PUSH_BIT] && !flush_req;
  assign pop        = op_valid && op_ready;

  // The pushed entry carries the mode from this very CTRL write, not the previously staged one.
  assign push_entry = {stage_q.x[DATA_W-1:0], stage_q.y[DATA_W-1:0],
                       stage_q.z[DATA_W-1:0], bus_data_in[CTRL_MODE_BIT]};

  cordic_op_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_req),
    .pop_i  (pop),
    .flush_i(flush_req),
    .wdata_i(push_entry),
    .rdata_o(head_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign op_valid = !fifo_empty;
  assign {op_x, op_y, op_z, op_mode} = head_entry;
  assign bus_data_out = rdata_q;

  always_comb begin
    stage_d = stage_q;
    if (bus_wr) begin
      if (sel_x)    stage_d.x = CORDIC_MAX_W'(signed'(wr_operand));
      if (sel_y)    stage_d.y = CORDIC_MAX_W'(signed'(wr_operand));
      if (sel_z)    stage_d.z = CORDIC_MAX_W'(signed'(wr_operand));
      if (sel_ctrl) stage_d.mode = bus_data_in[CTRL_MODE_BIT];
    end
  end

  // Clear is applied first so a same-cycle rejected push leaves overflow set.
  always_comb begin
    overflow_d = overflow_q;
    if (bus_wr && sel_status && bus_data_in[STAT_OVF_BIT]) overflow_d = 1'b0;
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY_BIT] = fifo_empty;
    status_word[STAT_FULL_BIT]  = fifo_full;
    status_word[STAT_OVF_BIT]   = overflow_q;
    status_word[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (bus_rd) begin
      rdata_d = '0;
      if (sel_x)      rdata_d = stage_q.x;
      if (sel_y)      rdata_d = stage_q.y;
      if (sel_z)      rdata_d = stage_q.z;
      if (sel_ctrl)   rdata_d[CTRL_MODE_BIT] = stage_q.mode;
      if (sel_status) rdata_d = status_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q    <= '{x: '0, y: '0, z: '0, mode: MODE_ROT};
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      stage_q    <= stage_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cordic_operand_queue.sv
// tb/tb_cordic_operand_queue.sv - self-checking bench for cordic_operand_queue with a queue-level reference model
module tb_cordic_operand_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic        mode;
  } m_entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  bus_addr = '0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_data_in = '0;
  logic [31:0] bus_data_out;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [31:0] op_x, op_y, op_z;
  logic        op_mode;

  logic [5:0]  b_addr = '0;
  logic        b_wr = 1'b0;
  logic        b_rd = 1'b0;
  logic [31:0] b_data_in = '0;
  logic [31:0] b_data_out;
  logic        b_valid;
  logic [15:0] b_x, b_y, b_z;
  logic        b_mode;

  int n_cmp = 0;
  int n_bad = 0;

  m_entry_t    mq[$];
  logic [31:0] m_x, m_y, m_z, m_rd;
  logic        m_mode, m_ovf;

  always #5 clk = ~clk;

  cordic_operand_queue #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_data_in(bus_data_in),
    .bus_rd(bus_rd), .bus_data_out(bus_data_out), .op_valid(op_valid), .op_ready(op_ready),
    .op_x(op_x), .op_y(op_y), .op_z(op_z), .op_mode(op_mode)
  );

  cordic_operand_queue #(.DATA_W(16), .DEPTH(DEPTH), .ADDR_W(6)) dut16 (
    .clk(clk), .rst(rst), .bus_addr(b_addr), .bus_wr(b_wr), .bus_data_in(b_data_in),
    .bus_rd(b_rd), .bus_data_out(b_data_out), .op_valid(b_valid), .op_ready(1'b0),
    .op_x(b_x), .op_y(b_y), .op_z(b_z), .op_mode(b_mode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    case (a)
      6'd0:    return m_x;
      6'd1:    return m_y;
      6'd2:    return m_z;
      6'd3:    return {30'b0, m_mode, 1'b0};
      6'd4:    return {16'b0, 8'(mq.size()), 5'b0, m_ovf, 1'(mq.size() == DEPTH), 1'(mq.size() == 0)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_x = '0; m_y = '0; m_z = '0; m_rd = '0;
    m_mode = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int n;
    bit pop, push_req, flush;
    m_entry_t e;
    n        = mq.size();
    pop      = (n != 0) && op_ready;
    flush    = bus_wr && bus_addr == 6'd3 && bus_data_in[2];
    push_req = bus_wr && bus_addr == 6'd3 && bus_data_in[0] && !flush;
    if (bus_rd) m_rd = m_read(bus_addr);
    if (bus_wr && bus_addr == 6'd4 && bus_data_in[2]) m_ovf = 1'b0;
    if (bus_wr) begin
      case (bus_addr)
        6'd0: m_x = bus_data_in;
        6'd1: m_y = bus_data_in;
        6'd2: m_z = bus_data_in;
        6'd3: m_mode = bus_data_in[1];
        default: ;
      endcase
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push_req) begin
        if (n < DEPTH || pop) begin
          e.x = m_x; e.y = m_y; e.z = m_z; e.mode = bus_data_in[1];
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus_addr = a; bus_data_in = d; bus_wr = 1'b1;
    tick();
    bus_wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    bus_addr = a; bus_rd = 1'b1;
    tick();
    bus_rd = 1'b0;
    chk(name, bus_data_out, exp);
  endtask

  task automatic push_set(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    wr(6'd0, kk << 8);
    wr(6'd1, kk);
    wr(6'd2, ~kk);
    wr(6'd3, {30'b0, kk[0], 1'b1});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("op_valid", 32'(op_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("head_x", op_x, mq[0].x);
        chk("head_y", op_y, mq[0].y);
        chk("head_z", op_z, mq[0].z);
        chk("head_mode", 32'(op_mode), 32'(mq[0].mode));
      end
      chk("rd_data", bus_data_out, m_rd);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_valid", 32'(op_valid), 32'h0);
    rd_chk("reset_status", 6'd4, 32'h0000_0001);

    wr(6'd0, 32'h0000_1000);
    wr(6'd1, 32'hFFFF_F000);
    wr(6'd2, 32'h0000_4000);
    wr(6'd3, 32'h0000_0003);
    chk("push_valid", 32'(op_valid), 32'h1);
    chk("push_x", op_x, 32'h0000_1000);
    chk("push_y", op_y, 32'hFFFF_F000);
    chk("push_z", op_z, 32'h0000_4000);
    chk("push_mode", 32'(op_mode), 32'h1);
    rd_chk("push_status", 6'd4, 32'h0000_0100);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    rd_chk("pop_status", 6'd4, 32'h0000_0001);

    for (int k = 1; k <= 5; k++) push_set(k);
    rd_chk("ovf_status", 6'd4, 32'h0000_0406);
    chk("ovf_head_x", op_x, 32'h0000_0100);
    wr(6'd4, 32'h0000_0004);
    rd_chk("ovf_clear", 6'd4, 32'h0000_0402);

    bus_addr = 6'd3; bus_data_in = 32'h0000_0003; bus_wr = 1'b1; op_ready = 1'b1;
    tick();
    bus_wr = 1'b0; op_ready = 1'b0;
    rd_chk("full_push_pop", 6'd4, 32'h0000_0402);
    op_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("drain_x", op_x, 32'(k * 256));
      tick();
    end
    op_ready = 1'b0;
    rd_chk("drained", 6'd4, 32'h0000_0001);

    wr(6'd0, 32'hAAAA_0001);
    for (int k = 0; k < 3; k++) wr(6'd3, 32'h0000_0001);
    rd_chk("flush_pre", 6'd4, 32'h0000_0300);
    bus_addr = 6'd3; bus_data_in = 32'h0000_0005; bus_wr = 1'b1; op_ready = 1'b1;
    tick();
    bus_wr = 1'b0; op_ready = 1'b0;
    chk("flush_valid", 32'(op_valid), 32'h0);
    rd_chk("flush_status", 6'd4, 32'h0000_0001);
    rd_chk("flush_xstage", 6'd0, 32'hAAAA_0001);
    rd_chk("ctrl_mode_rot", 6'd3, 32'h0);

    bus_addr = 6'd0; bus_data_in = 32'h1234_5678; bus_wr = 1'b1; bus_rd = 1'b1;
    tick();
    bus_wr = 1'b0; bus_rd = 1'b0;
    chk("rw_same_cycle", bus_data_out, 32'hAAAA_0001);
    rd_chk("rw_after", 6'd0, 32'h1234_5678);
    wr(6'd3, 32'h0000_0002);
    rd_chk("ctrl_mode_vec", 6'd3, 32'h0000_0002);
    rd_chk("mode_only_no_push", 6'd4, 32'h0000_0001);
    wr(6'd7, 32'hFFFF_FFFF);
    rd_chk("unmapped_read", 6'd7, 32'h0);

    wr(6'd3, 32'h0000_0001);
    wr(6'd3, 32'h0000_0003);
    rd_chk("pre_reset_status", 6'd4, 32'h0000_0200);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_valid", 32'(op_valid), 32'h0);
    chk("rst_async_rdata", bus_data_out, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_chk("rst_status", 6'd4, 32'h0000_0001);
    rd_chk("rst_xstage", 6'd0, 32'h0);

    b_addr = 6'd0; b_data_in = 32'h0001_8000; b_wr = 1'b1;
    tick();
    b_addr = 6'd3; b_data_in = 32'h0000_0001;
    tick();
    b_wr = 1'b0;
    chk("w16_valid", 32'(b_valid), 32'h1);
    chk("w16_x", 32'(b_x), 32'h0000_8000);
    chk("w16_y", 32'(b_y), 32'h0);
    chk("w16_mode", 32'(b_mode), 32'h0);
    b_addr = 6'd0; b_rd = 1'b1;
    tick();
    chk("w16_xread", b_data_out, 32'hFFFF_8000);
    b_addr = 6'd7;
    tick();
    b_rd = 1'b0;
    chk("w16_unmapped", b_data_out, 32'h0);
    chk("w16_z", 32'(b_z), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
